pwm_modulator: RTL and testbench

Center-aligned PWM modulator that turns the saturated control voltage from the PI/PID controller into complementary gate drives for the power stage. It takes a signed Q8.24 command and maps it linearly onto a triangular carrier. The duty change is applied only at the carrier valley. A valley strobe is issued so the ADC and Kalman filter sample the plant synchronously with the switching.

---
 rtl/pwm_modulator.sv | 161 ++++++++++++++++
 tb/tb_pwm_modulator.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_modulator.sv
// Center-aligned PWM modulator: Q8.24 command -> compare value, valley-synchronous duty update.
// Define PWM_MODULATOR_DEADTIME_EN to insert DT cycles of dead time on each gate's rising edge.
module pwm_modulator #(
    parameter int unsigned        PERIOD = 1000,
    parameter logic signed [31:0] VMIN   = 32'shF600_0000,
    parameter logic signed [31:0] VMAX   = 32'sh0A00_0000,
    parameter int unsigned        SCALE  = 12800
`ifdef PWM_MODULATOR_DEADTIME_EN
    ,
    parameter int unsigned        DT     = 20
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] vc,
    input  logic        vc_valid,
    output logic        gate_hi,
    output logic        gate_lo,
    output logic        sample_req,
    output logic [15:0] cmp_active
);

    localparam logic [15:0] PERIOD_C = 16'(PERIOD);
    localparam logic [13:0] SCALE_C  = 14'(SCALE);
    localparam logic [32:0] VMIN_X   = {VMIN[31], VMIN};

    // ------------------------------------------------------------------
    // Capture pipeline: clamp + offset, then scale to a compare value
    // ------------------------------------------------------------------
    logic signed [31:0] vc_clamped;
    logic        [32:0] off_d;
    logic        [32:0] off_q;
    logic               s1_valid;
    logic        [46:0] prod;
    logic        [46:0] quo;
    logic        [15:0] cmp_new;
    logic        [15:0] shadow;
    logic               pending;

    // NOTE: every branch assigns vc_clamped, so this decodes as pure logic with no latch.
    always_comb begin
        if ($signed(vc) < VMIN) begin
            vc_clamped = VMIN;
        end else if ($signed(vc) > VMAX) begin
            vc_clamped = VMAX;
        end else begin
            vc_clamped = $signed(vc);
        end
    end

    assign off_d   = {vc_clamped[31], vc_clamped} - VMIN_X;
    assign prod    = 47'(off_q) * 47'(SCALE_C);
    assign quo     = prod >> 32;
    assign cmp_new = (quo > 47'(PERIOD_C)) ? PERIOD_C : quo[15:0];

    // ------------------------------------------------------------------
    // Triangular carrier: 0 -> PERIOD -> 1 -> 0, period 2*PERIOD cycles
    // ------------------------------------------------------------------
    logic [15:0] cnt;
    logic        cnt_up;
    logic        valley;

    assign valley = (cnt == 16'd0);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= 16'd0;
            cnt_up <= 1'b1;
        end else if (cnt_up) begin
            if (cnt == PERIOD_C) begin
                cnt    <= PERIOD_C - 16'd1;
                cnt_up <= 1'b0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end else begin
            if (cnt == 16'd1) begin
                cnt    <= 16'd0;
                cnt_up <= 1'b1;
            end else begin
                cnt <= cnt - 16'd1;
            end
        end
    end

    // A stage-2 write landing on a valley keeps pending set, so it loads one carrier later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            off_q      <= 33'd0;
            shadow     <= 16'd0;
            pending    <= 1'b0;
            cmp_active <= 16'd0;
        end else begin
            s1_valid <= vc_valid;
            if (vc_valid) begin
                off_q <= off_d;
            end
            if (s1_valid) begin
                shadow <= cmp_new;
            end
            if (valley && pending) begin
                cmp_active <= shadow;
            end
            if (s1_valid) begin
                pending <= 1'b1;
            end else if (valley) begin
                pending <= 1'b0;
            end
        end
    end

    // Gated by rst so the strobe stays low while reset holds the carrier at its valley.
    assign sample_req = rst && valley;

    // ------------------------------------------------------------------
    // Raw PWM and gate drive
    // ------------------------------------------------------------------
    logic raw;

    assign raw = (cmp_active == PERIOD_C) || (cnt < cmp_active);

`ifdef PWM_MODULATOR_DEADTIME_EN
    localparam logic [15:0] DT_C = 16'(DT);

    // Each run counter saturates at DT; a gate turns on only once its level has held that long.
    logic [15:0] hi_run;
    logic [15:0] lo_run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_run  <= 16'd0;
            lo_run  <= 16'd0;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else begin
            if (raw) begin
                hi_run <= (hi_run == DT_C) ? DT_C : hi_run + 16'd1;
                lo_run <= 16'd0;
            end else begin
                lo_run <= (lo_run == DT_C) ? DT_C : lo_run + 16'd1;
                hi_run <= 16'd0;
            end
            gate_hi <= raw && (hi_run == DT_C);
            gate_lo <= !raw && (lo_run == DT_C);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else begin
            gate_hi <= raw;
            gate_lo <= !raw;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_modulator.sv
// Self-checking bench for pwm_modulator: randomized and directed commands against a
// carrier-phase / command-queue reference model. Honors PWM_MODULATOR_DEADTIME_EN.
`timescale 1ns/1ps
module tb_pwm_modulator;

    localparam int     P       = 1000;
    localparam int     CAR     = 2 * P;
    localparam longint VMIN_M  = -64'sd167772160;
    localparam longint VMAX_M  = 64'sd167772160;
    localparam longint SCALE_M = 64'sd12800;
`ifdef PWM_MODULATOR_DEADTIME_EN
    localparam int     DT_ADJ  = 20;
`else
    localparam int     DT_ADJ  = 0;
`endif
    localparam int     NEED    = DT_ADJ + 1;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        vc_valid = 1'b0;
    logic [31:0] vc       = 32'd0;
    logic        gate_hi;
    logic        gate_lo;
    logic        sample_req;
    logic [15:0] cmp_active;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int elig;
        int val;
    } cmd_t;

    cmd_t cmdq[$];
    int   n       = 0;
    int   exp_cmp = 0;
    int   hi_run  = 0;
    int   lo_run  = 0;
    logic s_ghi   = 1'b0;

    always #5 clk = ~clk;

    pwm_modulator dut (
        .clk       (clk),
        .rst       (rst),
        .vc        (vc),
        .vc_valid  (vc_valid),
        .gate_hi   (gate_hi),
        .gate_lo   (gate_lo),
        .sample_req(sample_req),
        .cmp_active(cmp_active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at n=%0d: got %0d, expected %0d", tag, n, got, exp);
        end
    endtask

    function automatic int carrier(input int k);
        int ph;
        ph = k % CAR;
        return (ph <= P) ? ph : CAR - ph;
    endfunction

    function automatic int map_cmd(input logic [31:0] v);
        longint x;
        longint c;
        x = longint'($signed(v));
        if (x < VMIN_M) x = VMIN_M;
        if (x > VMAX_M) x = VMAX_M;
        c = ((x - VMIN_M) * SCALE_M) / (64'sd1 <<< 32);
        if (c > P) c = P;
        return int'(c);
    endfunction

    function automatic int exp_high(input int c);
        int h;
        if (c == P) return CAR;
        if (c == 0) return 0;
        h = 2 * c - 1 - DT_ADJ;
        return (h < 0) ? 0 : h;
    endfunction

    // One clock cycle: compare outputs of cycle n at the falling edge, then advance the model.
    task automatic tick();
        logic raw;
        cmd_t c;
        @(negedge clk);
        raw   = (exp_cmp == P) || (carrier(n) < exp_cmp);
        s_ghi = gate_hi;
        check("cmp_active", 32'(cmp_active), 32'(exp_cmp));
        check("sample_req", 32'(sample_req), 32'((n % CAR) == 0));
        check("gate_hi", 32'(gate_hi), 32'(hi_run >= NEED));
        check("gate_lo", 32'(gate_lo), 32'(lo_run >= NEED));
        check("no_overlap", 32'(gate_hi & gate_lo), 32'd0);
        @(posedge clk);
        #1;
        if (raw) begin
            hi_run++;
            lo_run = 0;
        end else begin
            lo_run++;
            hi_run = 0;
        end
        if ((n % CAR) == 0) begin
            while (cmdq.size() > 0 && cmdq[0].elig <= n) begin
                c       = cmdq.pop_front();
                exp_cmp = c.val;
            end
        end
        n++;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic run_to_phase(input int ph);
        for (int i = 0; i < CAR && (n % CAR) != ph; i++) tick();
    endtask

    task automatic strobe(input logic [31:0] v);
        cmd_t c;
        vc       = v;
        vc_valid = 1'b1;
        c.elig   = n + 2;
        c.val    = map_cmd(v);
        cmdq.push_back(c);
        tick();
        vc_valid = 1'b0;
        vc       = $urandom();
    endtask

    task automatic reset_dut(input int cycles);
        rst      = 1'b0;
        vc_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("rst_sample_req", 32'(sample_req), 32'd0);
            if (i > 0) begin
                check("rst_gate_hi", 32'(gate_hi), 32'd0);
                check("rst_gate_lo", 32'(gate_lo), 32'd0);
                check("rst_cmp_active", 32'(cmp_active), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        rst     = 1'b1;
        n       = 0;
        exp_cmp = 0;
        hi_run  = 0;
        lo_run  = 0;
        cmdq.delete();
    endtask

    // Load a command, then count gate_hi over one peak-to-peak window of the following carrier.
    task automatic settle_count(input logic [31:0] v, input int want_cmp, input string tag);
        int cnt_hi;
        cnt_hi = 0;
        run_to_phase(10);
        strobe(v);
        run_to_phase(0);
        tick();
        check({tag, "_cmp"}, 32'(cmp_active), 32'(want_cmp));
        run_to_phase(P + 1);
        for (int i = 0; i < CAR; i++) begin
            tick();
            cnt_hi += int'(s_ghi);
        end
        check({tag, "_high_cycles"}, 32'(cnt_hi), 32'(exp_high(want_cmp)));
    endtask

    initial begin
        reset_dut(5);
        run(3);

        settle_count(32'h0000_0000, 500, "mid");
        settle_count(32'h7FFF_FFFF, 1000, "sat_hi");
        settle_count(32'h8000_0000, 0, "sat_lo");
        settle_count(32'hF619_999A, 5, "narrow");

        // Deferred load: command arrives at cnt=300 on the up-slope
        run_to_phase(300);
        strobe(32'h0500_0000);
        run_to_phase(0);
        check("defer_hold", 32'(cmp_active), 32'd5);
        tick();
        check("defer_load", 32'(cmp_active), 32'd750);

        // Last value wins when two strobes land before one valley
        run_to_phase(100);
        strobe(32'h0500_0000);
        run(2);
        strobe(32'hFB00_0000);
        run_to_phase(0);
        tick();
        check("last_wins", 32'(cmp_active), 32'd250);

        // Stage-2 write coincides with the valley: load slips one carrier
        run_to_phase(CAR - 1);
        strobe(32'h0280_0000);
        tick();
        check("collide_hold", 32'(cmp_active), 32'd250);
        run_to_phase(0);
        tick();
        check("collide_load", 32'(cmp_active), 32'd625);

        // Reset mid-carrier with cmp=700 and a command still in flight
        run_to_phase(10);
        strobe(32'h0400_0000);
        run_to_phase(0);
        tick();
        check("pre_reset_cmp", 32'(cmp_active), 32'd700);
        run_to_phase(600);
        strobe(32'h0500_0000);
        reset_dut(5);
        run(2 * CAR + 10);
        check("post_reset_cmp", 32'(cmp_active), 32'd0);

        // Randomized commands at random times, in and out of range
        for (int k = 0; k < 10; k++) begin
            logic [31:0] v;
            run($urandom_range(1, 2500));
            if ($urandom_range(0, 3) == 0) v = $urandom();
            else v = 32'hF600_0000 + 32'($urandom_range(0, 32'h1400_0000));
            strobe(v);
        end
        run(2 * CAR + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
